hist2d_bin_stream: RTL and testbench

Two-dimensional histogram engine for IQ readout data. It accumulates per-bin hit counts in an internal single-port RAM, one count per incoming (I, Q) bin coordinate. On command it streams out the non-zero bins in raster order. It sits between the IQ binning stage and the host readout path.

---
 rtl/hist2d_bin_stream.sv | 165 ++++++++++++++++
 tb/tb_hist2d_bin_stream.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hist2d_bin_stream.sv
// 2-D histogram engine: accumulates (I,Q) hits in a single-port RAM and streams non-zero bins.
// Optional HIST2D_CLEAR_ON_READ_EN: streaming zeroes each bin as it is read.
module hist2d_bin_stream #(
  parameter int COORD_W = 8,
  parameter int COUNT_W = 16,
  parameter int ADDR_W  = 16
) (
  input  logic               clk100,
  input  logic               reset_n,
  input  logic               data_in,
  input  logic [COORD_W-1:0] i_bin_coord,
  input  logic [COORD_W-1:0] q_bin_coord,
  input  logic [COORD_W-1:0] i_bin_num,
  input  logic [COORD_W-1:0] q_bin_num,
  input  logic [COUNT_W-1:0] num_data_pts,
  input  logic               start_data_out,
  input  logic               clear,
  output logic               data_out,
  output logic [COUNT_W-1:0] bin_val,
  output logic [COORD_W-1:0] i_bin_out,
  output logic [COORD_W-1:0] q_bin_out,
  output logic               busy,
  output logic               done
);

  localparam int NW = 2 * COORD_W;
  localparam int FW = ADDR_W + 2 * COORD_W;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WR   = 3'd2;
  localparam logic [2:0] SO_RD   = 3'd3;
  localparam logic [2:0] SO_EMIT = 3'd4;
  localparam logic [2:0] CLR     = 3'd5;

  logic [2:0]         state;
  logic [COORD_W-1:0] cur_i, cur_q;
  logic [COUNT_W-1:0] run_sum;
  logic [NW-1:0]      clr_cnt;
  logic [NW-1:0]      n_bins;

  logic [COUNT_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [COUNT_W-1:0] rd_data;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [COUNT_W-1:0] ram_wdata;

  logic               bins_empty, in_range, last_bin, emit, stream_end;
  logic [COUNT_W-1:0] rd_inc, emit_val, new_sum;
  logic [COUNT_W:0]   sum_ext;

  function automatic logic [ADDR_W-1:0] bin_addr(input logic [COORD_W-1:0] i,
                                                 input logic [COORD_W-1:0] q,
                                                 input logic [COORD_W-1:0] nq);
    logic [FW-1:0] full;
    full = FW'(i) * FW'(nq) + FW'(q);
    return full[ADDR_W-1:0];
  endfunction

  assign busy       = (state != IDLE);
  assign n_bins     = NW'(i_bin_num) * NW'(q_bin_num);
  assign bins_empty = (i_bin_num == '0) || (q_bin_num == '0);
  assign in_range   = (i_bin_coord < i_bin_num) && (q_bin_coord < q_bin_num);
  assign last_bin   = (cur_i == i_bin_num - COORD_W'(1)) && (cur_q == q_bin_num - COORD_W'(1));
  assign rd_inc     = (&rd_data) ? rd_data : rd_data + COUNT_W'(1);
  assign emit       = !bins_empty && (rd_data != '0);
  assign emit_val   = emit ? rd_data : '0;
  assign sum_ext    = {1'b0, run_sum} + {1'b0, emit_val};
  assign new_sum    = sum_ext[COUNT_W] ? '1 : sum_ext[COUNT_W-1:0];
  // The sum test only fires on an emitted bin, so num_data_pts=0 still emits the first non-zero bin.
  assign stream_end = bins_empty || last_bin || (emit && (new_sum >= num_data_pts));

  always_comb begin
    ram_we    = 1'b0;
    ram_wdata = '0;
    ram_addr  = bin_addr(cur_i, cur_q, q_bin_num);
    case (state)
      ST_WR: begin
        ram_we    = 1'b1;
        ram_wdata = rd_inc;
      end
`ifdef HIST2D_CLEAR_ON_READ_EN
      SO_EMIT: begin
        ram_we    = !bins_empty;
        ram_wdata = '0;
      end
`endif
      CLR: begin
        ram_addr = ADDR_W'(clr_cnt);
        ram_we   = (clr_cnt < n_bins);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rd_data <= mem[ram_addr];
  end

  always_ff @(posedge clk100 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= CLR;
      cur_i     <= '0;
      cur_q     <= '0;
      run_sum   <= '0;
      clr_cnt   <= '0;
      data_out  <= 1'b0;
      bin_val   <= '0;
      i_bin_out <= '0;
      q_bin_out <= '0;
      done      <= 1'b0;
    end else begin
      data_out <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (clear) begin
            clr_cnt <= '0;
            state   <= CLR;
          end else if (start_data_out) begin
            cur_i   <= '0;
            cur_q   <= '0;
            run_sum <= '0;
            state   <= SO_RD;
          end else if (data_in && in_range) begin
            cur_i <= i_bin_coord;
            cur_q <= q_bin_coord;
            state <= ST_RD;
          end
        end
        ST_RD:   state <= ST_WR;
        ST_WR:   state <= IDLE;
        SO_RD:   state <= SO_EMIT;
        SO_EMIT: begin
          if (emit) begin
            data_out  <= 1'b1;
            bin_val   <= rd_data;
            i_bin_out <= cur_i;
            q_bin_out <= cur_q;
            run_sum   <= new_sum;
          end
          if (stream_end) begin
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            if (cur_q == q_bin_num - COORD_W'(1)) begin
              cur_q <= '0;
              cur_i <= cur_i + COORD_W'(1);
            end else begin
              cur_q <= cur_q + COORD_W'(1);
            end
            state <= SO_RD;
          end
        end
        CLR: begin
          if (clr_cnt < n_bins) clr_cnt <= clr_cnt + NW'(1);
          else                  state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hist2d_bin_stream.sv
// Self-checking bench for hist2d_bin_stream: directed tables, corner sequences, random rounds vs. a bin-array model.
module tb_hist2d_bin_stream;
  localparam int CW   = 8;
  localparam int MAXV = (1 << CW) - 1;

  logic          clk100, reset_n, data_in, start_data_out, clear;
  logic [7:0]    i_bin_coord, q_bin_coord, i_bin_num, q_bin_num;
  logic [CW-1:0] num_data_pts;
  logic          data_out, busy, done;
  logic [CW-1:0] bin_val;
  logic [7:0]    i_bin_out, q_bin_out;

  hist2d_bin_stream #(.COORD_W(8), .COUNT_W(CW), .ADDR_W(16)) dut (
    .clk100(clk100), .reset_n(reset_n), .data_in(data_in),
    .i_bin_coord(i_bin_coord), .q_bin_coord(q_bin_coord),
    .i_bin_num(i_bin_num), .q_bin_num(q_bin_num), .num_data_pts(num_data_pts),
    .start_data_out(start_data_out), .clear(clear), .data_out(data_out),
    .bin_val(bin_val), .i_bin_out(i_bin_out), .q_bin_out(q_bin_out),
    .busy(busy), .done(done)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  typedef struct { int i; int q; int v; } bin_t;
  typedef struct { int ic; int qc; bit exp_busy; } rng_vec_t;

  int   n_pass = 0, n_total = 0;
  int   model [256][256];
  bin_t got_q[$], exp_q[$];
  int   done_cyc, first_lat, exp_done;
  rng_vec_t rng_tab[7];

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int pack(input bin_t b);
    return b.i * 65536 + b.q * 256 + b.v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 256; i++)
      for (int q = 0; q < 256; q++) model[i][q] = 0;
  endtask

  task automatic model_store(input int i, input int q);
    if (i < int'(i_bin_num) && q < int'(q_bin_num) && model[i][q] < MAXV)
      model[i][q] = model[i][q] + 1;
  endtask

  // Raster walk over the bin array; reading a bin costs two cycles after a 3-cycle lead-in.
  task automatic model_stream(input int num, output int exp_d);
    int sum, last, v, ni, nq;
    bit stop;
    exp_q.delete();
    sum = 0; last = 0; stop = 0;
    ni = int'(i_bin_num); nq = int'(q_bin_num);
    for (int i = 0; i < ni && !stop; i++)
      for (int q = 0; q < nq && !stop; q++) begin
        last = i * nq + q;
        v = model[i][q];
`ifdef HIST2D_CLEAR_ON_READ_EN
        model[i][q] = 0;
`endif
        if (v != 0) begin
          exp_q.push_back('{i, q, v});
          sum = (sum + v > MAXV) ? MAXV : sum + v;
          if (sum >= num) stop = 1;
        end
      end
    exp_d = 3 + 2 * last;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int k = 0; k < max_cyc; k++) begin
      if (!busy) break;
      @(negedge clk100);
    end
    if (busy) begin
      n_total++;
      $display("FAIL wait_idle: busy still %0d after %0d cycles, expected 0", busy, max_cyc);
    end
  endtask

  task automatic store(input int i, input int q);
    i_bin_coord = 8'(i); q_bin_coord = 8'(q);
    @(negedge clk100) data_in = 1'b1;
    @(negedge clk100) data_in = 1'b0;
    model_store(i, q);
    wait_idle(10);
  endtask

  task automatic run_stream(input int num);
    int cyc;
    got_q.delete();
    num_data_pts = CW'(num);
    @(negedge clk100) start_data_out = 1'b1;
    @(negedge clk100) start_data_out = 1'b0;
    cyc = 1; first_lat = -1; done_cyc = -1;
    while (cyc <= 600) begin
      if (data_out) begin
        got_q.push_back('{int'(i_bin_out), int'(q_bin_out), int'(bin_val)});
        if (first_lat < 0) first_lat = cyc;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk100);
      cyc++;
    end
    if (done_cyc < 0) begin
      n_total++;
      $display("FAIL stream_timeout: no done within %0d cycles, expected one", cyc);
    end
  endtask

  task automatic cmp_stream(input string name, input int exp_d);
    int n;
    check({name, "_nstrobes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) check({name, "_bin"}, pack(got_q[k]), pack(exp_q[k]));
    check({name, "_done_cyc"}, done_cyc, exp_d);
    check({name, "_busy_at_done"}, int'(busy), 0);
  endtask

  task automatic stream_and_check(input string name, input int num);
    model_stream(num, exp_done);
    run_stream(num);
    cmp_stream(name, exp_done);
  endtask

  task automatic do_clear(input int exp_cycles, input bit with_others);
    int  cnt;
    bit  seen_done;
    @(negedge clk100);
    clear = 1'b1;
    if (with_others) begin
      start_data_out = 1'b1; data_in = 1'b1; i_bin_coord = 8'd1; q_bin_coord = 8'd1;
    end
    @(negedge clk100);
    clear = 1'b0; start_data_out = 1'b0; data_in = 1'b0;
    cnt = 0; seen_done = 0;
    for (int k = 0; k < 400; k++) begin
      if (!busy) break;
      if (done) seen_done = 1;
      cnt++;
      @(negedge clk100);
    end
    check("clear_cycles", cnt, exp_cycles);
    if (with_others) check("clear_priority_no_done", int'(seen_done), 0);
    model_clear();
  endtask

  task automatic count_reset_clr(input int exp_cycles);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk100);
      if (!busy) break;
      cnt++;
    end
    check("reset_clr_cycles", cnt, exp_cycles);
  endtask

  initial begin
    int ni, nq, k_pts, num, r;
    bit seen;

    rng_tab[0] = '{0, 0, 1'b1};
    rng_tab[1] = '{9, 9, 1'b1};
    rng_tab[2] = '{10, 0, 1'b0};
    rng_tab[3] = '{0, 10, 1'b0};
    rng_tab[4] = '{9, 10, 1'b0};
    rng_tab[5] = '{255, 255, 1'b0};
    rng_tab[6] = '{5, 3, 1'b1};

    reset_n = 1'b0; data_in = 1'b0; start_data_out = 1'b0; clear = 1'b0;
    i_bin_coord = '0; q_bin_coord = '0; i_bin_num = 8'd10; q_bin_num = 8'd10;
    num_data_pts = '0;
    model_clear();

    repeat (3) @(negedge clk100);
    check("reset_data_out", int'(data_out), 0);
    check("reset_done", int'(done), 0);
    check("reset_busy", int'(busy), 1);
    check("reset_bin_outs", int'(bin_val) + int'(i_bin_out) + int'(q_bin_out), 0);
    reset_n = 1'b1;
    count_reset_clr(100);

    // Degenerate bin counts
    i_bin_num = 8'd0;
    stream_and_check("empty_bins", 255);
    do_clear(1, 1'b0);
    i_bin_num = 8'd10;
    do_clear(101, 1'b0);

    // Range check table at 10x10
    foreach (rng_tab[k]) begin
      i_bin_coord = 8'(rng_tab[k].ic); q_bin_coord = 8'(rng_tab[k].qc);
      @(negedge clk100) data_in = 1'b1;
      @(negedge clk100) data_in = 1'b0;
      check("range_busy", int'(busy), int'(rng_tab[k].exp_busy));
      model_store(rng_tab[k].ic, rng_tab[k].qc);
      wait_idle(10);
    end
    stream_and_check("range_tab", 255);

    // Basic accumulation plus repeat-stream behaviour
    do_clear(101, 1'b0);
    for (int k = 0; k < 5; k++) store(k, k);
    stream_and_check("basic", 5);
    check("basic_first_latency", first_lat, 3);
    stream_and_check("basic_repeat", 5);
    do_clear(101, 1'b0);
    stream_and_check("after_clear", 255);

    do_clear(101, 1'b0);
    repeat (3) store(2, 7);
    stream_and_check("repeated_hits", 3);

    do_clear(101, 1'b0);
    store(10, 0);
    check("oor_busy_low", int'(busy), 0);
    stream_and_check("out_of_range", 1);

    do_clear(101, 1'b0);
    repeat (MAXV + 2) store(0, 0);
    stream_and_check("saturation", MAXV);

    do_clear(101, 1'b0);
    store(3, 4); store(5, 6);
    stream_and_check("num_zero", 0);

    // Back-to-back data_in: the second pulse lands in ST_RD and is dropped
    do_clear(101, 1'b0);
    i_bin_coord = 8'd1; q_bin_coord = 8'd1;
    @(negedge clk100) data_in = 1'b1;
    @(negedge clk100) begin i_bin_coord = 8'd2; q_bin_coord = 8'd2; end
    @(negedge clk100) data_in = 1'b0;
    model_store(1, 1);
    wait_idle(10);
    stream_and_check("busy_drop", 255);

    do_clear(101, 1'b1);
    stream_and_check("priority_clear", 255);

    // Randomized rounds
    for (int rnd = 0; rnd < 8; rnd++) begin
      ni = $urandom_range(1, 12); nq = $urandom_range(1, 12);
      i_bin_num = 8'(ni); q_bin_num = 8'(nq);
      do_clear(ni * nq + 1, 1'b0);
      k_pts = $urandom_range(5, 30);
      for (int k = 0; k < k_pts; k++) store($urandom_range(0, 13), $urandom_range(0, 13));
      for (int s = 0; s < 2; s++) begin
        r = $urandom_range(0, 3);
        num = (r == 0) ? 0 : (r == 1) ? $urandom_range(1, k_pts) : MAXV;
        stream_and_check("random", num);
      end
    end

    // Async reset in the middle of a stream
    i_bin_num = 8'd10; q_bin_num = 8'd10;
    do_clear(101, 1'b0);
    store(0, 0); store(3, 3); store(9, 9);
    num_data_pts = CW'(MAXV);
    @(negedge clk100) start_data_out = 1'b1;
    @(negedge clk100) start_data_out = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (data_out) begin seen = 1; break; end
      @(negedge clk100);
    end
    check("async_saw_strobe", int'(seen), 1);
    reset_n = 1'b0;
    #1;
    check("async_data_out", int'(data_out), 0);
    check("async_done", int'(done), 0);
    check("async_busy", int'(busy), 1);
    check("async_bin_val", int'(bin_val), 0);
    @(negedge clk100);
    @(negedge clk100) reset_n = 1'b1;
    count_reset_clr(100);
    model_clear();
    stream_and_check("after_async", MAXV);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
